// File: rtl/bcd_scan_scheduler.sv
// Converts NF binary 0..99 time fields through one shared external BCD converter,
// then multiplexes the committed digits onto an active-low scanned display.
module bcd_scan_scheduler #(
  parameter int NF       = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7*NF-1:0] fields_in,
  output logic [6:0]      conv_in,
  input  logic [3:0]      conv_ones,
  input  logic [3:0]      conv_tens,
  output logic            busy,
  output logic            done,
  output logic [3:0]      bcd_out,
  output logic [2*NF-1:0] an_n
);

  localparam int ND = 2 * NF;
  localparam int IW = (NF > 1) ? $clog2(NF) : 1;
  localparam int PW = $clog2(ND);
  localparam int DW = $clog2(SCAN_DIV);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_CAPT   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [IW-1:0] IDX_LAST = IW'(NF - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(ND - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [ND-1:0] SEL_ONE  = ND'(1);

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [6:0]    r_snap [NF];
  logic [7:0]    r_work [NF];
  logic [7:0]    r_disp [NF];
  logic          r_done;
  logic [DW-1:0] r_div;
  logic [PW-1:0] r_ptr;
  logic [IW-1:0] w_fsel;
  logic [7:0]    w_dfield;

  // Frame sequencer: one DRIVE (converter settle) + one CAPT cycle per field.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      for (int unsigned i = 0; i < NF; i++) begin
        r_snap[i] <= '0;
        r_work[i] <= '0;
        r_disp[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NF; i++) begin
              r_snap[i] <= fields_in[7*i +: 7];
            end
            r_idx   <= '0;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: r_state <= S_CAPT;
        S_CAPT: begin
          r_work[r_idx] <= {conv_tens, conv_ones};
          if (r_idx == IDX_LAST) begin
            r_state <= S_COMMIT;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= S_DRIVE;
          end
        end
        S_COMMIT: begin
          for (int unsigned i = 0; i < NF; i++) begin
            r_disp[i] <= r_work[i];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Free-running scan; never touched by the sequencer so bank swaps cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_ptr <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PW'(1);
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign conv_in  = r_snap[r_idx];
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign w_fsel   = IW'(r_ptr >> 1);
  assign w_dfield = r_disp[w_fsel];
  assign bcd_out  = r_ptr[0] ? w_dfield[7:4] : w_dfield[3:0];
  assign an_n     = ~(SEL_ONE << r_ptr);

endmodule
